// File: rtl/mem_pkg.sv
// Purpose: shared types for the memory-port arbiter (state encoding, mask modes, grant ids).
// Latency: n/a, declarations only.
// Backpressure: n/a.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

endpackage

// File: rtl/arb_rr2.sv
// Purpose: two-way round-robin picker; bit 0 is fetch, bit 1 is data.
// Latency: combinational, zero cycles.
// Backpressure: none; gnt is one-hot or zero, tie goes to the side that did not win last.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // on a tie, last=1 (data won before) hands the grant to fetch and vice versa
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between fetch and load/store, with timeout and illegal-request errors.
// Latency: request sampled in IDLE at cycle t -> good at t+2 on a zero-wait memory; illegal data request -> t+1.
// Backpressure: requesters hold valid until their good pulse; the loser waits at most one access of the other side.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    output logic          i_good,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_valid,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic          d_memRead,
    input  logic          d_memWrite,
    input  logic [1:0]    d_maskMode,
    input  logic          d_sext,
    output logic          d_good,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          m_valid,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_writeData,
    output logic          m_memRead,
    output logic          m_memWrite,
    output logic [1:0]    m_maskMode,
    output logic          m_sext,
    input  logic          m_good,
    input  logic [31:0]   m_readData
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          rd;
        logic          wr;
        logic [1:0]    mask;
        logic          sext;
    } req_t;

    arb_state_t    state;
    grant_t        last_grant;
    req_t          mreq;
    logic [CW-1:0] cnt;
    logic [1:0]    gnt;
    logic          d_illegal;
    logic [31:0]   cap_dat;
    logic          timed_out;

    arb_rr2 u_arb (
        .req  ({d_valid, i_valid}),
        .last (last_grant == GRANT_D),
        .gnt  (gnt)
    );

    assign d_illegal = (d_memRead == d_memWrite);
    assign cap_dat   = mreq.wr ? 32'd0 : m_readData;
    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    assign m_addr      = mreq.addr;
    assign m_writeData = mreq.wdata;
    assign m_memRead   = mreq.rd;
    assign m_memWrite  = mreq.wr;
    assign m_maskMode  = mreq.mask;
    assign m_sext      = mreq.sext;

    // arbitration FSM: grant in IDLE, wait for memory or timeout in BUSY, pulse good in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_I;
            mreq       <= '0;
            cnt        <= '0;
            m_valid    <= 1'b0;
            i_good     <= 1'b0;
            i_rdata    <= 32'd0;
            i_err      <= 1'b0;
            d_good     <= 1'b0;
            d_rdata    <= 32'd0;
            d_err      <= 1'b0;
        end else begin
            i_good <= 1'b0;
            d_good <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (gnt[0]) begin
                        last_grant <= GRANT_I;
                        mreq       <= '{addr: i_addr, wdata: 32'd0, rd: 1'b1, wr: 1'b0,
                                        mask: MASK_W, sext: 1'b0};
                        m_valid    <= 1'b1;
                        state      <= ST_BUSY_I;
                    end else if (gnt[1]) begin
                        last_grant <= GRANT_D;
                        if (d_illegal) begin
                            // malformed request is answered locally, memory never sees it
                            d_good  <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 32'd0;
                            state   <= ST_RESP;
                        end else begin
                            mreq    <= '{addr: d_addr, wdata: d_wdata, rd: d_memRead,
                                         wr: d_memWrite, mask: d_maskMode, sext: d_sext};
                            m_valid <= 1'b1;
                            state   <= ST_BUSY_D;
                        end
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (m_good || timed_out) begin
                        m_valid <= 1'b0;
                        state   <= ST_RESP;
                        if (state == ST_BUSY_I) begin
                            i_good  <= 1'b1;
                            i_rdata <= m_good ? cap_dat : 32'd0;
                            i_err   <= ~m_good;
                        end else begin
                            d_good  <= 1'b1;
                            d_rdata <= m_good ? cap_dat : 32'd0;
                            d_err   <= ~m_good;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed scoreboard bench for mem_port_arbiter with a small wait-state memory model.
// Latency: checks good latency per access against hand-computed cycle counts.
// Backpressure: requesters hold valid until good, as the arbiter expects.
module tb_mem_port_arbiter;

    localparam int TO = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid, d_valid;
    logic [AW-1:0] i_addr, d_addr;
    logic [31:0]   d_wdata;
    logic          d_memRead, d_memWrite, d_sext;
    logic [1:0]    d_maskMode;
    logic          i_good, i_err, d_good, d_err;
    logic [31:0]   i_rdata, d_rdata;
    logic          m_valid, m_memRead, m_memWrite, m_sext;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_writeData, m_readData;
    logic [1:0]    m_maskMode;
    logic          m_good;

    mem_port_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_good(i_good), .i_rdata(i_rdata), .i_err(i_err),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_memRead(d_memRead),
        .d_memWrite(d_memWrite), .d_maskMode(d_maskMode), .d_sext(d_sext),
        .d_good(d_good), .d_rdata(d_rdata), .d_err(d_err),
        .m_valid(m_valid), .m_addr(m_addr), .m_writeData(m_writeData), .m_memRead(m_memRead),
        .m_memWrite(m_memWrite), .m_maskMode(m_maskMode), .m_sext(m_sext),
        .m_good(m_good), .m_readData(m_readData)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          passed = 0;
    int          mem_wait = 0;
    bit          mem_never = 1'b0;
    logic [31:0] mem_xor = 32'h0000_0003;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input bit is_d, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_d = is_d; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    // wait for the requested good pulse; lat counts negedges, vcnt counts m_valid-high cycles
    task automatic wait_good(input bit is_d, output int lat, output int vcnt);
        bit done = 1'b0;
        lat = 0; vcnt = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            lat++;
            if (m_valid) vcnt++;
            if (is_d ? d_good : i_good) done = 1'b1;
        end
        if (!done) begin
            total++;
            $display("FAIL wait_good(%0d): no good pulse within 40 cycles", is_d);
        end
    endtask

    // memory model: m_good after mem_wait wait cycles, data = address xor mem_xor
    initial begin
        int busy_cnt = 0;
        m_good = 1'b0;
        m_readData = 32'd0;
        forever begin
            @(negedge clk);
            if (!m_valid) begin
                busy_cnt = 0;
                m_good = 1'b0;
            end else begin
                m_good = !mem_never && (busy_cnt == mem_wait);
                m_readData = m_addr ^ mem_xor;
                busy_cnt++;
            end
        end
    end

    // scoreboard monitor: pop and compare on every good pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_good && d_good) begin
                total++;
                $display("FAIL both_good: i_good and d_good high together");
            end else if (i_good || d_good) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL extra_good: i_good=%0b d_good=%0b with nothing expected", i_good, d_good);
                end else begin
                    e = sb.pop_front();
                    chk("good_port", {63'd0, d_good}, {63'd0, e.is_d});
                    chk("rdata", {32'd0, d_good ? d_rdata : i_rdata}, {32'd0, e.rdata});
                    chk("err", {63'd0, d_good ? d_err : i_err}, {63'd0, e.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, vcnt;
        reset = 1'b1;
        i_valid = 0; i_addr = '0;
        d_valid = 0; d_addr = '0; d_wdata = '0; d_memRead = 0; d_memWrite = 0;
        d_maskMode = 2'b00; d_sext = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {56'd0, m_valid, i_good, d_good, i_err, d_err, m_memRead, m_memWrite, m_sext}, 64'd0);
        chk("reset_rdata", {i_rdata, d_rdata}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 2: simultaneous requests after reset -> D, then I (tie re-presented by D), then D again
        i_valid = 1; i_addr = 32'h20;
        d_valid = 1; d_addr = 32'h40; d_memRead = 1; d_memWrite = 0; d_maskMode = 2'b10;
        push(1'b1, 32'h43, 1'b0);
        push(1'b0, 32'h23, 1'b0);
        wait_good(1'b1, lat, vcnt);
        chk("tie1_lat", 64'(lat), 64'd2);
        d_addr = 32'h44;
        push(1'b1, 32'h47, 1'b0);
        wait_good(1'b0, lat, vcnt);
        i_valid = 0;
        wait_good(1'b1, lat, vcnt);
        d_valid = 0;
        @(negedge clk);

        // 1: lone fetch, zero-wait memory
        i_valid = 1; i_addr = 32'h10;
        push(1'b0, 32'h13, 1'b0);
        @(negedge clk);
        chk("fetch_mfields", {m_addr, 28'd0, m_memRead, m_memWrite, m_maskMode}, {32'h10, 28'd0, 1'b1, 1'b0, 2'b10});
        wait_good(1'b0, lat, vcnt);
        chk("fetch_lat", 64'(lat + 1), 64'd2);
        i_valid = 0;
        @(negedge clk);

        // 3: byte store with 4 wait cycles; m_* must stay stable for 5 cycles
        mem_wait = 4;
        d_valid = 1; d_addr = 32'h3; d_wdata = 32'hAB; d_memRead = 0; d_memWrite = 1; d_maskMode = 2'b00;
        push(1'b1, 32'h0, 1'b0);
        lat = 0; vcnt = 0;
        for (int k = 0; k < 40 && !d_good; k++) begin
            @(negedge clk);
            lat++;
            if (m_valid) begin
                vcnt++;
                chk("store_mfields", {m_addr, m_writeData[27:0], m_memRead, m_memWrite, m_maskMode},
                    {32'h3, 28'hAB, 1'b0, 1'b1, 2'b00});
            end
        end
        chk("store_vcnt", 64'(vcnt), 64'd5);
        chk("store_lat", 64'(lat), 64'd6);
        d_valid = 0;
        mem_wait = 0;
        @(negedge clk);

        // 4: memory never answers -> timeout after exactly TO cycles of m_valid
        mem_never = 1;
        d_valid = 1; d_addr = 32'h80; d_memRead = 1; d_memWrite = 0; d_maskMode = 2'b10;
        push(1'b1, 32'h0, 1'b1);
        wait_good(1'b1, lat, vcnt);
        chk("timeout_vcnt", 64'(vcnt), 64'(TO));
        chk("timeout_lat", 64'(lat), 64'(TO + 1));
        d_valid = 0;
        mem_never = 0;
        @(negedge clk);

        // 5: read and write together, then neither -> local error, memory untouched
        d_valid = 1; d_memRead = 1; d_memWrite = 1;
        push(1'b1, 32'h0, 1'b1);
        wait_good(1'b1, lat, vcnt);
        chk("illegal_rw_lat", 64'(lat), 64'd1);
        chk("illegal_rw_mvalid", 64'(vcnt), 64'd0);
        d_memRead = 0; d_memWrite = 0;
        push(1'b1, 32'h0, 1'b1);
        @(negedge clk);
        wait_good(1'b1, lat, vcnt);
        chk("illegal_none_mvalid", 64'(vcnt), 64'd0);
        d_valid = 0;
        @(negedge clk);

        // 6: reset during BUSY_D discards the access; pending fetch served afterwards
        mem_never = 1;
        d_valid = 1; d_addr = 32'h90; d_memRead = 1; d_memWrite = 0;
        repeat (3) @(negedge clk);
        chk("busy_mvalid", {63'd0, m_valid}, 64'd1);
        reset = 1; d_valid = 0; i_valid = 1; i_addr = 32'h30;
        @(negedge clk);
        chk("rst_mid_mvalid", {61'd0, m_valid, d_good, d_err}, 64'd0);
        @(negedge clk);
        mem_never = 0;
        reset = 0;
        push(1'b0, 32'h33, 1'b0);
        wait_good(1'b0, lat, vcnt);
        chk("post_rst_lat", 64'(lat), 64'd2);
        i_valid = 0;
        repeat (3) @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
